// File: rtl/multdiv_sched_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_sched_pkg: shared encodings for the mul/div scheduler slice.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package multdiv_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int WDOG_W = 8;

endpackage

`default_nettype wire

// File: rtl/multdiv_scheduler_arb.sv
// ---------------------------------------------------------------------------
// rr_arbiter2: two-way round-robin grant with a last-grant flop.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2
  import multdiv_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  // On a tie the requester not served last wins; last_q resets to 1 so port 0 wins first.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (update_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multdiv_scheduler.sv
// ---------------------------------------------------------------------------
// multdiv_scheduler: two-port sequencer for the shared iterative mul/div unit.
// Optional watchdog abort enabled by MULTDIV_SCHED_TIMEOUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multdiv_scheduler
  import multdiv_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_result,
  output logic        resp0_exception,
  output logic        resp1_valid,
  output logic [31:0] resp1_result,
  output logic        resp1_exception,
  input  logic        flush0,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        md_interrupt,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready
);

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic        owner_q, owner_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  logic [1:0]  w_req, w_gnt;
  logic        w_arb_upd, w_flush_hit, w_flush_abort, w_tmo_abort, w_start, w_resp;

  assign w_req       = {req1_valid, req0_valid & ~flush0};
  assign w_flush_hit = flush0 & ~owner_q;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (w_req),
    .update_i (w_arb_upd),
    .gnt_o    (w_gnt)
  );

`ifdef MULTDIV_SCHED_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              w_wdog_exp;
  // BUSY cycle k after the start pulse sees wdog_q == k-1.
  assign w_wdog_exp = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    owner_d       = owner_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    result_d      = result_q;
    exc_d         = exc_q;
    w_arb_upd     = 1'b0;
    w_flush_abort = 1'b0;
    w_tmo_abort   = 1'b0;
    w_start       = 1'b0;
    w_resp        = 1'b0;
`ifdef MULTDIV_SCHED_TIMEOUT_EN
    wdog_d        = wdog_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_gnt != 2'b00) begin
          w_arb_upd = 1'b1;
          owner_d   = w_gnt[1];
          op_d      = w_gnt[1] ? req1_op : req0_op;
          opa_d     = w_gnt[1] ? req1_a  : req0_a;
          opb_d     = w_gnt[1] ? req1_b  : req0_b;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (w_flush_hit) begin
          w_flush_abort = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          w_start = 1'b1;
`ifdef MULTDIV_SCHED_TIMEOUT_EN
          wdog_d  = '0;
`endif
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Flush beats a coincident finish; finish beats a coincident timeout.
        if (w_flush_hit) begin
          w_flush_abort = 1'b1;
          state_d       = ST_IDLE;
        end else if (md_ready) begin
          result_d = md_result;
          exc_d    = md_exception;
          state_d  = ST_RESP;
        end
`ifdef MULTDIV_SCHED_TIMEOUT_EN
        else if (w_wdog_exp) begin
          w_tmo_abort = 1'b1;
          result_d    = '0;
          exc_d       = 1'b1;
          state_d     = ST_RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        w_resp  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULT;
      owner_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef MULTDIV_SCHED_TIMEOUT_EN
      wdog_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      owner_q  <= owner_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      exc_q    <= exc_d;
`ifdef MULTDIV_SCHED_TIMEOUT_EN
      wdog_q   <= wdog_d;
`endif
    end
  end

  assign req0_ready      = ~reset & w_arb_upd & w_gnt[0];
  assign req1_ready      = ~reset & w_arb_upd & w_gnt[1];
  assign md_ctrl_mult    = ~reset & w_start & (op_q == OP_MULT);
  assign md_ctrl_div     = ~reset & w_start & (op_q == OP_DIV);
  assign md_interrupt    = reset | w_flush_abort | w_tmo_abort;
  assign md_operandA     = opa_q;
  assign md_operandB     = opb_q;

  assign resp0_valid     = ~reset & w_resp & ~owner_q;
  assign resp1_valid     = ~reset & w_resp & owner_q;
  assign resp0_result    = resp0_valid ? result_q : '0;
  assign resp1_result    = resp1_valid ? result_q : '0;
  assign resp0_exception = resp0_valid & exc_q;
  assign resp1_exception = resp1_valid & exc_q;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_scheduler.sv
// ---------------------------------------------------------------------------
// tb_multdiv_scheduler: directed and randomized checks of the mul/div scheduler.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multdiv_scheduler;
  import multdiv_sched_pkg::*;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_op, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_op, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic        resp0_valid, resp0_exception, resp1_valid, resp1_exception;
  logic [31:0] resp0_result, resp1_result;
  logic        flush0;
  logic [31:0] md_operandA, md_operandB, md_result;
  logic        md_ctrl_mult, md_ctrl_div, md_interrupt, md_exception, md_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int last_m   = 1;

  always #5 clk = ~clk;

  multdiv_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_result(resp0_result), .resp0_exception(resp0_exception),
    .resp1_valid(resp1_valid), .resp1_result(resp1_result), .resp1_exception(resp1_exception),
    .flush0(flush0),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div), .md_interrupt(md_interrupt),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behaviour of the iterative unit: {exception, result}.
  function automatic logic [32:0] unit_calc(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (op == OP_MULT) begin
      p = 64'(a) * 64'(b);
      return {|p[63:32], p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF};
    return {1'b0, a / b};
  endfunction

  // fl: 0 none, 1 flush0 during START, 2 flush0 together with the unit finish.
  task automatic transact(input logic v0, input logic v1, input logic op0, input logic op1,
                          input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1,
                          input int lat, input int fl);
    int          win;
    logic        op;
    logic [31:0] a, b;
    logic [32:0] u, expv;
    logic        killed;
    win = (v0 && v1) ? ((last_m == 1) ? 0 : 1) : (v0 ? 0 : 1);
    op  = win ? op1 : op0;
    a   = win ? a1 : a0;
    b   = win ? b1 : b0;
    last_m = win;

    @(negedge clk);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    flush0 = 1'b0;
    md_ready = 1'($urandom % 2); md_result = $urandom; md_exception = 1'($urandom % 2);
    #1;
    check("ready0", req0_ready, win == 0);
    check("ready1", req1_ready, win == 1);
    check("idle_quiet", {resp0_valid, resp1_valid, md_ctrl_mult, md_ctrl_div}, 4'b0);

    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    md_ready = 1'($urandom % 2); md_result = $urandom;
    flush0 = (fl == 1);
    killed = (fl == 1) && (win == 0);
    #1;
    check("ctrl_mult", md_ctrl_mult, !killed && op == OP_MULT);
    check("ctrl_div", md_ctrl_div, !killed && op == OP_DIV);
    check("int_start", md_interrupt, killed);
    if (killed) begin
      @(negedge clk);
      flush0 = 1'b0; md_ready = 1'b0;
      #1 check("flush_start_noresp", {resp0_valid, resp1_valid}, 2'b0);
      return;
    end
    check("opA", md_operandA, a);
    check("opB", md_operandB, b);

    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      flush0 = 1'b0; md_ready = 1'b0; md_result = $urandom;
      #1 check("busy_quiet", {md_interrupt, md_ctrl_mult, md_ctrl_div, resp0_valid, resp1_valid}, 5'b0);
    end

    @(negedge clk);
    u = unit_calc(op, md_operandA, md_operandB);
    md_ready = 1'b1; md_result = u[31:0]; md_exception = u[32];
    flush0 = (fl == 2);
    killed = (fl == 2) && (win == 0);
    #1;
    check("opA_hold", md_operandA, a);
    check("int_finish", md_interrupt, killed);
    check("finish_noresp", {resp0_valid, resp1_valid}, 2'b0);

    @(negedge clk);
    md_ready = 1'($urandom % 2); md_result = $urandom; md_exception = 1'($urandom % 2);
    flush0 = 1'($urandom % 2);
    expv = unit_calc(op, a, b);
    #1;
    check("resp0_valid", resp0_valid, !killed && win == 0);
    check("resp1_valid", resp1_valid, !killed && win == 1);
    if (!killed) begin
      check("resp_result", win ? resp1_result : resp0_result, expv[31:0]);
      check("resp_exc", win ? resp1_exception : resp0_exception, expv[32]);
    end
  endtask

  task automatic reset_mid();
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b1; req1_op = OP_DIV; req1_a = 50; req1_b = 7;
    flush0 = 1'b0; md_ready = 1'b0;
    #1 check("rst_grant", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; md_ready = 1'b1; md_result = 32'hDEAD; req0_valid = 1'b1;
    #1;
    check("rst_int", md_interrupt, 1);
    check("rst_quiet", {resp0_valid, resp1_valid, md_ctrl_mult, md_ctrl_div, req0_ready, req1_ready}, 6'b0);
    @(negedge clk);
    reset = 1'b0; req0_valid = 1'b0; md_ready = 1'b0;
    #1;
    check("rst_opA_clr", md_operandA, 0);
    check("rst_after_quiet", {md_interrupt, resp0_valid, resp1_valid}, 3'b0);
    last_m = 1;
  endtask

`ifdef MULTDIV_SCHED_TIMEOUT_EN
  task automatic timeout_test();
    int c;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = OP_MULT; req0_a = 5; req0_b = 5; req1_valid = 1'b0;
    flush0 = 1'b0; md_ready = 1'b0;
    #1 check("tmo_ready", req0_ready, 1);
    last_m = 0;
    @(negedge clk);
    req0_valid = 1'b0;
    #1 check("tmo_start", md_ctrl_mult, 1);
    c = 0;
    while (c < TMO + 5) begin
      @(negedge clk);
      c++;
      #1;
      if (md_interrupt) break;
    end
    check("tmo_cycles", c, TMO);
    @(negedge clk);
    #1;
    check("tmo_valid", resp0_valid, 1);
    check("tmo_result", resp0_result, 0);
    check("tmo_exc", resp0_exception, 1);
  endtask
`endif

  initial begin
    logic [1:0]  r;
    logic [31:0] ra0, rb0, ra1, rb1;
    int          sel;
    reset = 1'b1;
    req0_valid = 1'b1; req0_op = OP_MULT; req0_a = 0; req0_b = 0;
    req1_valid = 1'b1; req1_op = OP_MULT; req1_a = 0; req1_b = 0;
    flush0 = 1'b0; md_result = 0; md_exception = 1'b0; md_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_int", md_interrupt, 1);
    check("reset_quiet", {req0_ready, req1_ready, resp0_valid, resp1_valid, md_ctrl_mult, md_ctrl_div}, 6'b0);
    check("reset_opA", md_operandA, 0);
    check("reset_opB", md_operandB, 0);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

    transact(1, 0, OP_MULT, OP_MULT, 7, 6, 0, 0, 3, 0);
    transact(1, 1, OP_MULT, OP_DIV, 3, 4, 100, 5, 2, 0);
    transact(0, 1, OP_MULT, OP_DIV, 0, 0, 100, 5, 2, 0);
    transact(1, 1, OP_MULT, OP_DIV, 3, 4, 100, 5, 1, 0);
    transact(1, 0, OP_MULT, OP_DIV, 3, 4, 100, 5, 1, 0);
    transact(0, 1, OP_MULT, OP_DIV, 0, 0, 9, 0, 4, 0);
    transact(1, 0, OP_MULT, OP_MULT, 7, 8, 0, 0, 2, 2);
    transact(0, 1, OP_MULT, OP_MULT, 0, 0, 11, 3, 2, 0);
    transact(1, 1, OP_DIV, OP_MULT, 81, 9, 11, 3, 1, 1);
    transact(0, 1, OP_MULT, OP_MULT, 0, 0, 32'h1_0000, 32'h1_0000, 2, 1);

    @(negedge clk);
    req0_valid = 1'b1; flush0 = 1'b1; req1_valid = 1'b0;
    #1 check("flush_idle_block", req0_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; flush0 = 1'b0;

    reset_mid();
    transact(1, 0, OP_MULT, OP_MULT, 2, 2, 0, 0, 2, 0);

    for (int i = 0; i < 30; i++) begin
      r   = 2'($urandom_range(1, 3));
      ra0 = ($urandom % 2) ? $urandom : $urandom % 1000;
      rb0 = ($urandom % 6 == 0) ? 32'd0 : (($urandom % 2) ? $urandom : $urandom % 1000);
      ra1 = ($urandom % 2) ? $urandom : $urandom % 1000;
      rb1 = ($urandom % 6 == 0) ? 32'd0 : (($urandom % 2) ? $urandom : $urandom % 1000);
      sel = $urandom_range(0, 5);
      transact(r[0], r[1], 1'($urandom % 2), 1'($urandom % 2), ra0, rb0, ra1, rb1,
               $urandom_range(1, 5), (sel == 1) ? 1 : ((sel == 2) ? 2 : 0));
    end

`ifdef MULTDIV_SCHED_TIMEOUT_EN
    timeout_test();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multdiv_scheduler.md
# multdiv_scheduler

Sequencer and two-way arbiter for the shared iterative multiply/divide unit. It accepts operations from two requesters: port 0 is the CPU pipeline, port 1 is the game-logic coprocessor (score/level arithmetic). It grants one operation at a time, issues the single-cycle start pulse, and waits for the unit's finish flag. It then returns the 32-bit result and exception flag to the owning requester, and uses the unit's interrupt input to abort flushed or timed-out operations.

## Interface
- TIMEOUT_CYCLES, 40: watchdog limit in cycles, counted from the start pulse; used only with the timeout macro.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- reqN_valid  in  1  (N = 0, 1) operation request.
- reqN_op  in  1  0 = multiply, 1 = divide.
- reqN_a, reqN_b  in  32 each  operands (a = multiplicand/dividend).
- reqN_ready  out  1  high in the cycle reqN is accepted.
- respN_valid  out  1  one-cycle result strobe.
- respN_result  out  32  result, valid with respN_valid.
- respN_exception  out  1  overflow / divide-by-zero / timeout, valid with respN_valid.
- flush0  in  1  pipeline flush; kills requester 0's pending or in-flight operation.
- md_operandA, md_operandB  out  32 each  operands to the unit, held stable from START until the operation ends.
- md_ctrl_mult, md_ctrl_div  out  1 each  one-cycle start pulses.
- md_interrupt  out  1  abort/clear to the unit.
- md_result  in  32  unit result.
- md_exception  in  1  unit overflow/exception.
- md_ready  in  1  unit finish flag.

## Operation
- States: IDLE, START, BUSY, RESP.
- IDLE:
  - Eligible requests are req0_valid&~flush0 and req1_valid.
  - If either is eligible, grant round-robin: the winner is the requester not granted last when both request, otherwise the sole requester.
  - Assert the winner's reqN_ready, latch op, a, b and owner, update last_grant, go to START.
- START:
  - Drive md_ctrl_mult or md_ctrl_div high for exactly this cycle.
  - Clear the watchdog counter, go to BUSY.
- BUSY:
  - Wait for md_ready.
  - On md_ready, capture md_result into the result register and md_exception into the exception register, then go to RESP.
- RESP:
  - Assert respN_valid for the owner for one cycle (no backpressure), then go to IDLE.
  - No new grant is made in this cycle.
- Flush (owner = 0, flush0 high in START or BUSY):
  - Assert md_interrupt for that cycle and suppress the start pulse.
  - Go to IDLE with no response.
  - Flush wins over a simultaneous md_ready, and that result is discarded.
  - flush0 in RESP is ignored; the response is still delivered.
- flush0 never affects owner 1.
- Operand registers stay unchanged outside IDLE; a requester may change its inputs after its ready cycle.
- md_interrupt = reset | flush-abort | timeout-abort. Holding it during reset clears the unit, which has no reset of its own.

## Timing
- Request accepted at cycle T (ready high).
- Start pulse at T+1.
- Unit finish at T+1+L, where L is the unit's latency (≥1).
- Response strobe at T+2+L.
- Back-to-back throughput: one operation per L+3 cycles.
- Reset values:
  - state = IDLE, last_grant = 1 (so port 0 wins the first tie).
  - All respN_*, reqN_ready, md_ctrl_* low, md_operand* zero.
  - md_interrupt high while reset is high.
- Reset mid-operation: abort immediately, no response issued, next cycle is IDLE.
- md_ready outside BUSY is ignored.

## Configuration
- MULTDIV_SCHED_TIMEOUT_EN defined:
  - An 8-bit watchdog counts BUSY cycles.
  - On reaching TIMEOUT_CYCLES without md_ready, assert md_interrupt for one cycle and go to RESP.
  - The response carries result 0 and exception 1.
  - md_ready in the same cycle as the timeout wins over the timeout.
- Macro undefined: no counter; BUSY waits indefinitely for md_ready or flush.

## Structure
- Shared package multdiv_sched_pkg holds:
  - the state encoding (IDLE, START, BUSY, RESP);
  - the op encoding (OP_MULT = 0, OP_DIV = 1);
  - the watchdog counter width.
- Sub-module rr_arbiter2: 2-way round-robin grant with last_grant register and update enable. It is combinational grant plus one flop.

## Test plan
- Single multiply on port 0, a=7, b=6 → ready at T, md_ctrl_mult at T+1, resp0_valid with result 42 and exception 0 one cycle after md_ready.
- Both ports request at once from reset (port 0 mult 3×4, port 1 div 100/5) → port 0 granted first with result 12; port 1 follows with result 20. Repeating the tie grants port 1 first.
- Divide 9/0 on port 1 → resp1_exception = 1, and the op is still delivered to port 1.
- Port 0 multiply, flush0 asserted in BUSY concurrent with md_ready → md_interrupt for one cycle, no resp0_valid, next port 1 request granted.
- Reset asserted in BUSY → md_interrupt high, all responses low; after reset a fresh 2×2 returns 4.
- With MULTDIV_SCHED_TIMEOUT_EN and a stalled md_ready → md_interrupt exactly TIMEOUT_CYCLES cycles after start, response result 0, exception 1.
